// File: rtl/ls_pkg.sv
// ls_pkg: shared states, instruction field positions, size encodings and default timeout for ls_sequencer
package ls_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ACCESS, S_WB, S_ABORT} state_e;
  localparam int P_BIT = 24;
  localparam int U_BIT = 23;
  localparam int B_BIT = 22;
  localparam int W_BIT = 21;
  localparam int L_BIT = 20;
  localparam int RN_LSB = 16;
  localparam int RD_LSB = 12;
  localparam logic SZ_WORD = 1'b0;
  localparam logic SZ_BYTE = 1'b1;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/ls_sequencer_if.sv
// ls_sequencer_if: memory port (req/we/byte/addr/wdata out of master, ready/rdata back from slave)
interface ls_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_byte;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_byte, mem_addr, mem_wdata, input mem_ready, mem_rdata);
  modport slave (input mem_req, mem_we, mem_byte, mem_addr, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/ls_addr_unit.sv
// ls_addr_unit: combinational index/ea/aligned address, writeback enable, store lane replication, load rotate/extract
module ls_addr_unit
  import ls_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rn,
  input  logic [31:0] offset,
  input  logic [31:0] rd_value,
  input  logic [31:0] rdata,
  output logic [31:0] idx,
  output logic [31:0] ea,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        wb_en
);
  logic [5:0]  sh;
  logic [63:0] rot;
  always_comb begin
    idx = instr[U_BIT] ? rn + offset : rn - offset;
    ea = instr[P_BIT] ? idx : rn;
    wb_en = !instr[P_BIT] || instr[W_BIT];
    addr = (instr[B_BIT] == SZ_BYTE) ? ea : {ea[31:2], 2'b00};
    wdata = (instr[B_BIT] == SZ_BYTE) ? {4{rd_value[7:0]}} : rd_value;
    sh = {1'b0, ea[1:0], 3'b000};
    // doubling the word turns a right shift into a rotate; the low byte is the addressed lane
    rot = {rdata, rdata} >> sh;
    load_data = (instr[B_BIT] == SZ_BYTE) ? {24'd0, rot[7:0]} : rot[31:0];
  end
endmodule

// File: rtl/ls_sequencer.sv
// ls_sequencer: LDR/STR(B) sequencer; clk/reset, start+operands in, mem port (ls_sequencer_if.master), rd/rn write ports, busy/done/abort
module ls_sequencer
  import ls_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           instruction,
  input  logic [31:0]           rn_value,
  input  logic [31:0]           offset,
  input  logic [31:0]           rd_value,
  ls_sequencer_if.master        mem,
  output logic                  rd_we,
  output logic [31:0]           rd_wdata,
  output logic                  rn_we,
  output logic [31:0]           rn_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  abort
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e          state_q, state_d;
  logic [31:0]     instr_q, rn_q, off_q, rdv_q, addr_q, wdata_q, rd_wdata_q, rn_wdata_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     idx, ea, addr, wdata, load_data;
  logic            wb_en, expire, lq;
  ls_addr_unit u_addr (
    .instr(instr_q), .rn(rn_q), .offset(off_q), .rd_value(rdv_q), .rdata(mem.mem_rdata),
    .idx(idx), .ea(ea), .addr(addr), .wdata(wdata), .load_data(load_data), .wb_en(wb_en)
  );
  assign lq = instr_q[L_BIT];
  assign expire = cnt_q == CW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == S_IDLE   ? (start ? S_ADDR : S_IDLE) :
              state_q == S_ADDR   ? S_ACCESS :
              state_q == S_ACCESS ? (mem.mem_ready ? S_WB : expire ? S_ABORT : S_ACCESS) :
              S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      rn_q <= '0;
      off_q <= '0;
      rdv_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_wdata_q <= '0;
      rn_wdata_q <= '0;
      cnt_q <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        instr_q <= instruction;
        rn_q <= rn_value;
        off_q <= offset;
        rdv_q <= rd_value;
      end
      if (state_q == S_ADDR) begin
        addr_q <= addr;
        wdata_q <= wdata;
        rn_wdata_q <= idx;
        cnt_q <= '0;
      end
      if (state_q == S_ACCESS && !mem.mem_ready) cnt_q <= cnt_q + 1'b1;
      if (state_q == S_ACCESS && mem.mem_ready && lq) rd_wdata_q <= load_data;
    end
  end
  always_comb begin
    mem.mem_req = state_q == S_ACCESS;
    mem.mem_we = state_q == S_ACCESS && !lq;
    mem.mem_byte = state_q == S_ACCESS && instr_q[B_BIT] == SZ_BYTE;
    mem.mem_addr = addr_q;
    mem.mem_wdata = wdata_q;
    busy = state_q != S_IDLE;
    done = state_q == S_WB;
    abort = state_q == S_ABORT;
    rd_we = state_q == S_WB && lq;
    // a load into the base register takes priority over the base writeback
    rn_we = state_q == S_WB && wb_en && !(lq && instr_q[RN_LSB +: 4] == instr_q[RD_LSB +: 4]);
    rd_wdata = rd_wdata_q;
    rn_wdata = rn_wdata_q;
  end
endmodule

// File: doc/ls_sequencer.md
# ls_sequencer

Multi-cycle controller that executes ARM addressing-mode-2 single data transfers (LDR/STR/LDRB/STRB) over a shared memory port. It takes the decoded instruction, the base register value and the offset produced by the shift/sign-extend stage. It computes the effective address for offset, pre-indexed and post-indexed forms, and runs the memory request/acknowledge handshake with a timeout. It then returns the load data and base writeback to the register file. It sits between the decode stage and the memory interface, and holds the pipeline via `busy` while a transfer is in flight.

## Interface
- `TIMEOUT`, default 16: maximum cycles ACCESS waits for `mem_ready` before aborting (≥1).
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request a transfer; sampled only in IDLE.
- `instruction` input 32: transfer instruction. Fields: P=[24], U=[23], B=[22], W=[21], L=[20], Rn=[19:16], Rd=[15:12].
- `rn_value` input 32: base register contents.
- `offset` input 32: unsigned offset from the shift/sign-extend stage (immediate or shifted Rm).
- `rd_value` input 32: store data; caller supplies any PC adjustment.
- `mem_ready` input 1: memory acknowledge.
- `mem_rdata` input 32: read data, valid when `mem_ready`=1.
- `mem_req` output 1: request active.
- `mem_we` output 1: 1 = write.
- `mem_byte` output 1: 1 = byte access, 0 = word.
- `mem_addr` output 32: access address.
- `mem_wdata` output 32: write data.
- `rd_we`, `rd_wdata` output 1/32: load result write port.
- `rn_we`, `rn_wdata` output 1/32: base writeback port.
- `busy` output 1: high in every non-IDLE state.
- `done` output 1: one-cycle pulse on successful completion.
- `abort` output 1: one-cycle pulse on timeout.

## Operation
- States:
  - IDLE → ADDR on `start`.
  - ADDR → ACCESS, unconditional.
  - ACCESS → WB on `mem_ready`.
  - ACCESS → ABORT when wait count reaches `TIMEOUT`.
  - WB → IDLE.
  - ABORT → IDLE.
- On the `start` edge, latch `instruction`, `rn_value`, `offset` and `rd_value`. Inputs are don't-care afterwards.
- Index and address computation:
  - `idx` = U ? rn+offset : rn−offset, 32-bit, wrap-around modulo 2^32, no flags.
  - Effective address `ea` = P ? `idx` : `rn`.
  - Writeback when (P=1 ∧ W=1) ∨ P=0, with `rn_wdata`=`idx`.
- Word access:
  - `mem_addr` = {ea[31:2],2'b00}.
  - Load result = `mem_rdata` rotated right by 8×ea[1:0].
  - Store data = `rd_value` unchanged.
- Byte access:
  - `mem_addr` = `ea`.
  - Load result = zero-extended byte lane ea[1:0] of `mem_rdata`.
  - Store data = {4{rd_value[7:0]}}.
- WB state:
  - `rd_we` = L.
  - `rn_we` = writeback condition.
  - `done` = 1.
- Load with writeback and Rd==Rn: the load wins and `rn_we` is forced 0.
- ABORT state:
  - `abort` = 1.
  - No register writes.
  - `done` = 0.
- `start` while busy is ignored; no queuing.

## Timing
- Reset values:
  - State IDLE, wait count 0.
  - Outputs `mem_req`, `mem_we`, `mem_byte`, `rd_we`, `rn_we`, `busy`, `done` and `abort` all 0.
  - `mem_addr`, `mem_wdata`, `rd_wdata` and `rn_wdata` all 0.
- Reset mid-transfer returns to IDLE on that edge. `mem_req` is low the following cycle and no writes occur.
- Edge E0 samples `start`. Cycle after E0 is ADDR: `busy`=1, `mem_req`=0, address and write data registered.
- ACCESS:
  - `mem_req`=1 with `mem_addr`, `mem_we`, `mem_byte` and `mem_wdata` held stable until exit.
  - `mem_ready` is honoured only while `mem_req`=1.
  - `mem_rdata` is captured on the edge where `mem_ready`=1.
- Minimum latency: `done` asserted 3 cycles after E0, when `mem_ready` is high in the first ACCESS cycle.
- Wait count:
  - Cleared on ACCESS entry; increments each ACCESS cycle with `mem_ready`=0.
  - Reaching `TIMEOUT` enters ABORT. With `TIMEOUT`=16, `abort` pulses in the 18th cycle after E0.
  - `mem_ready`=1 on the same edge the count would expire: completion wins.
- `rd_we`/`rn_we`/`done`, and `abort`, are single-cycle pulses. A new `start` is accepted in the IDLE cycle immediately after WB or ABORT.

## Structure
- Package `ls_pkg`:
  - State enum.
  - Instruction field bit positions (P, U, B, W, L, Rn, Rd).
  - Size encodings.
  - Default `TIMEOUT`.
- Sub-module `ls_addr_unit` (combinational), which computes:
  - `idx`, `ea` and the aligned `mem_addr`;
  - the writeback enable;
  - store lane replication;
  - load rotate/extract.
- `ls_sequencer` holds:
  - the FSM;
  - the operand latches;
  - the wait counter;
  - the output registers.

## Test plan
- Pre-indexed word LDR, P=1 U=1 W=1:
  - Stimulus: rn=0x100, offset=4, `mem_ready` in the first ACCESS cycle, `mem_rdata`=0xDEADBEEF.
  - Response: `mem_addr`=0x104; `done` 3 cycles after `start`; `rd_wdata`=0xDEADBEEF; `rn_wdata`=0x104.
- Post-indexed STRB, P=0 U=0:
  - Stimulus: rn=0x203, offset=3, rd=0x123456AB.
  - Response: `mem_addr`=0x203, `mem_byte`=1, `mem_wdata`=0xABABABAB, `rn_wdata`=0x200, `rd_we`=0.
- Unaligned word LDR, P=1 W=0:
  - Stimulus: ea=0x102, `mem_rdata`=0x11223344.
  - Response: `mem_addr`=0x100, `rd_wdata`=0x33441122, `rn_we`=0.
- Timeout, `TIMEOUT`=4, `mem_ready` held 0:
  - `abort` pulses once.
  - No `rd_we`/`rn_we`/`done`.
  - IDLE follows.
  - A second `start` then completes normally.
- Wrap-around and conflicts:
  - rn=0xFFFFFFFC, offset=8, U=1, pre-indexed: `mem_addr`=0x4.
  - LDR with writeback and Rd==Rn: `rn_we`=0.
  - `start` asserted while busy: ignored.
- Reset asserted in ACCESS with 3 wait cycles elapsed: `mem_req` low next cycle, `busy`=0, no writes.
